// File: rtl/lc3_mem_pkg.sv
// Shared constants and FSM state type for the LC-3 memory/device controller.
package lc3_mem_pkg;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam int READY = 15;
    localparam int IE    = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic logic is_mmio(input logic [15:0] addr);
        return addr >= MMIO_BASE;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display/MCR registers, MMIO read mux and device handshakes.
// LC3_MEM_MCR_EN adds the MCR register at xFFFE and the run output.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [15:0] rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        kb_int
`ifdef LC3_MEM_MCR_EN
    ,
    output logic        run
`endif
);

    logic       kb_rdy_q, kb_rdy_d;
    logic       kb_ie_q, kb_ie_d;
    logic [7:0] kbdr_q, kbdr_d;
    logic       dsp_valid_q, dsp_valid_d;
    logic [7:0] dsp_data_q, dsp_data_d;
`ifdef LC3_MEM_MCR_EN
    logic [15:0] mcr_q, mcr_d;
`else
    logic unused_wdata;
    assign unused_wdata = ^{wdata[15], wdata[13:8]};
`endif

    always_comb begin
        kb_rdy_d    = kb_rdy_q;
        kb_ie_d     = kb_ie_q;
        kbdr_d      = kbdr_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
`ifdef LC3_MEM_MCR_EN
        mcr_d       = mcr_q;
`endif
        if (kb_valid && !kb_rdy_q) begin
            kb_rdy_d = 1'b1;
            kbdr_d   = kb_data;
        end
        if (rd_en && addr == KBDR_ADDR) kb_rdy_d = 1'b0;
        if (wr_en && addr == KBSR_ADDR) kb_ie_d = wdata[IE];
        if (dsp_valid_q && dsp_ready) dsp_valid_d = 1'b0;
        // A DDR write wins over a same-cycle display acceptance.
        if (wr_en && addr == DDR_ADDR) begin
            dsp_valid_d = 1'b1;
            dsp_data_d  = wdata[7:0];
        end
`ifdef LC3_MEM_MCR_EN
        if (wr_en && addr == MCR_ADDR) mcr_d = wdata;
`endif
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            kb_rdy_q    <= 1'b0;
            kb_ie_q     <= 1'b0;
            kbdr_q      <= 8'h00;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
`ifdef LC3_MEM_MCR_EN
            mcr_q       <= 16'h8000;
`endif
        end else begin
            kb_rdy_q    <= kb_rdy_d;
            kb_ie_q     <= kb_ie_d;
            kbdr_q      <= kbdr_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
`ifdef LC3_MEM_MCR_EN
            mcr_q       <= mcr_d;
`endif
        end
    end

    // DSR ready is exactly "no character pending", so it is derived rather than stored.
    always_comb begin
        rdata = 16'h0000;
        case (addr)
            KBSR_ADDR: begin
                rdata[READY] = kb_rdy_q;
                rdata[IE]    = kb_ie_q;
            end
            KBDR_ADDR: rdata = {8'h00, kbdr_q};
            DSR_ADDR:  rdata[READY] = !dsp_valid_q;
`ifdef LC3_MEM_MCR_EN
            MCR_ADDR:  rdata = mcr_q;
`endif
            default:   rdata = 16'h0000;
        endcase
    end

    assign kb_ready  = !kb_rdy_q;
    assign kb_int    = kb_rdy_q && kb_ie_q;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
`ifdef LC3_MEM_MCR_EN
    assign run       = mcr_q[15];
`endif

endmodule

// File: rtl/tsb_h.sv
// Tri-state bus driver: drives d onto y while en is high, releases it otherwise.
module tsb_h #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    inout  logic [WIDTH-1:0] y
);

    assign y = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, wait-state FSM, SRAM strobes and MMIO devices.
// LC3_MEM_MCR_EN enables the MCR register and the run port.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        arst,
    inout  logic [15:0] bus,
    output logic        rdy,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        gate_mdr,
    input  logic        mio_en,
    input  logic        rw,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        kb_int
`ifdef LC3_MEM_MCR_EN
    ,
    output logic        run
`endif
);

    localparam int WS_EFF = (WAIT_STATES < 1) ? 1 : ((WAIT_STATES > 15) ? 15 : WAIT_STATES);
    localparam logic [3:0] WS_LOAD = 4'(WS_EFF - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] hold_q, hold_d;
    logic        rd_pend_q, rd_pend_d;
    logic        issue, mmio, mmio_rd, mmio_wr;
    logic [15:0] mmio_rdata;

    // Strobes fire on the issue cycle; reset masks them so an aborted cycle never writes.
    assign issue      = (state_q == IDLE) && mio_en && !arst;
    assign mmio       = is_mmio(mar_q);
    assign sram_en    = issue && !mmio;
    assign sram_we    = sram_en && rw;
    assign sram_addr  = mar_q;
    assign sram_wdata = mdr_q;
    assign mmio_rd    = issue && mmio && !rw;
    assign mmio_wr    = issue && mmio && rw;
    assign rdy        = rdy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mio_en) begin
                    state_d = ACCESS;
                    cnt_d   = WS_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else cnt_d = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == DONE);
    end

    always_comb begin
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        hold_d    = hold_q;
        rd_pend_d = sram_en && !rw;
        if (ld_mar && state_q != ACCESS) mar_d = bus;
        if (ld_mdr) begin
            if (!mio_en) mdr_d = bus;
            else if (!rw && rdy_q) mdr_d = hold_q;
        end
        if (rd_pend_q) hold_d = sram_rdata;
        if (mmio_rd) hold_d = mmio_rdata;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            rdy_q     <= 1'b0;
            mar_q     <= 16'h0000;
            mdr_q     <= 16'h0000;
            hold_q    <= 16'h0000;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk       (clk),
        .arst      (arst),
        .addr      (mar_q),
        .wdata     (mdr_q),
        .rd_en     (mmio_rd),
        .wr_en     (mmio_wr),
        .rdata     (mmio_rdata),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .kb_ready  (kb_ready),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready),
        .kb_int    (kb_int)
`ifdef LC3_MEM_MCR_EN
        ,
        .run       (run)
`endif
    );

    tsb_h #(.WIDTH(16)) u_bus_drv (
        .d  (mdr_q),
        .en (gate_mdr),
        .y  (bus)
    );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl; MDR values gated onto the bus are checked by a monitor.
// Builds with or without LC3_MEM_MCR_EN.
module tb_lc3_mem_ctrl;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        arst;
    wire  [15:0] bus;
    logic        rdy;
    logic        ld_mar, ld_mdr, gate_mdr, mio_en, rw;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr, sram_wdata;
    logic [15:0] sram_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready, dsp_valid, dsp_ready, kb_int;
    logic [7:0]  dsp_data;
`ifdef LC3_MEM_MCR_EN
    logic        run;
`endif

    logic        tb_drv;
    logic [15:0] tb_bus;
    assign bus = tb_drv ? tb_bus : 16'hzzzz;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk        (clk),
        .arst       (arst),
        .bus        (bus),
        .rdy        (rdy),
        .ld_mar     (ld_mar),
        .ld_mdr     (ld_mdr),
        .gate_mdr   (gate_mdr),
        .mio_en     (mio_en),
        .rw         (rw),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .dsp_valid  (dsp_valid),
        .dsp_data   (dsp_data),
        .dsp_ready  (dsp_ready),
        .kb_int     (kb_int)
`ifdef LC3_MEM_MCR_EN
        ,
        .run        (run)
`endif
    );

    // Synchronous SRAM: read data appears the cycle after the strobe.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
            else sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (sram_we === 1'b1) we_cnt++;
        if (sram_en === 1'b1) en_cnt++;
    end

    // Monitor: every cycle the MDR is gated onto the bus, compare against the next expectation.
    always @(negedge clk) begin
        if (gate_mdr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mdr_unexpected: got %h with no expected value queued", bus);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus !== e) begin
                    errors++;
                    $display("FAIL mdr_data: got %h expected %h", bus, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] a);
        tb_bus = a; tb_drv = 1'b1; ld_mar = 1'b1;
        cyc();
        ld_mar = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic set_mdr(input logic [15:0] d);
        tb_bus = d; tb_drv = 1'b1; ld_mdr = 1'b1; mio_en = 1'b0;
        cyc();
        ld_mdr = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic mem_cycle(input logic wr);
        int n;
        n = 0;
        mio_en = 1'b1; rw = wr; ld_mdr = !wr;
        forever begin
            @(negedge clk);
            if (rdy === 1'b1) break;
            n++;
            if (n > 40) break;
        end
        chk("rdy_latency", 16'(n), 16'(WS + 1));
        @(posedge clk);
        #1;
        mio_en = 1'b0; ld_mdr = 1'b0; rw = 1'b0;
    endtask

    task automatic show_mdr(input logic [15:0] e);
        exp_q.push_back(e);
        gate_mdr = 1'b1;
        cyc();
        gate_mdr = 1'b0;
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
        set_mar(a);
        set_mdr(d);
        mem_cycle(1'b1);
    endtask

    task automatic mem_read(input logic [15:0] a, input logic [15:0] e);
        set_mar(a);
        mem_cycle(1'b0);
        show_mdr(e);
    endtask

    task automatic offer_key(input logic [7:0] k);
        kb_valid = 1'b1; kb_data = k;
        cyc();
        kb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, eb;
        arst = 1'b1; tb_drv = 1'b0; tb_bus = 16'h0000;
        ld_mar = 0; ld_mdr = 0; gate_mdr = 0; mio_en = 0; rw = 0;
        kb_valid = 0; kb_data = 8'h00; dsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 16'(rdy), 16'h0);
        chk("rst_sram_en", 16'(sram_en), 16'h0);
        chk("rst_sram_we", 16'(sram_we), 16'h0);
        chk("rst_sram_addr", sram_addr, 16'h0000);
        chk("rst_sram_wdata", sram_wdata, 16'h0000);
        chk("rst_kb_ready", 16'(kb_ready), 16'h1);
        chk("rst_dsp_valid", 16'(dsp_valid), 16'h0);
        chk("rst_dsp_data", 16'(dsp_data), 16'h0000);
        chk("rst_kb_int", 16'(kb_int), 16'h0);
`ifdef LC3_MEM_MCR_EN
        chk("rst_run", 16'(run), 16'h1);
`endif
        @(posedge clk); #1;
        arst = 1'b0;
        cyc();
        show_mdr(16'h0000);

        // SRAM write/read
        wb = we_cnt;
        mem_write(16'h3000, 16'h1234);
        chk("sram_we_pulses", 16'(we_cnt - wb), 16'd1);
        mem_read(16'h3000, 16'h1234);
        mem_write(16'h30FF, 16'hA5A5);
        mem_read(16'h30FF, 16'hA5A5);
        mem_read(16'h3000, 16'h1234);

        // Keyboard
        eb = en_cnt;
        offer_key(8'h41);
        @(negedge clk);
        chk("kb_ready_after_key", 16'(kb_ready), 16'h0);
        mem_read(16'hFE00, 16'h8000);
        mem_read(16'hFE02, 16'h0041);
        mem_read(16'hFE00, 16'h0000);
        @(negedge clk);
        chk("kb_ready_after_read", 16'(kb_ready), 16'h1);

        // Interrupt
        mem_write(16'hFE00, 16'h4000);
        @(negedge clk);
        chk("kb_int_no_key", 16'(kb_int), 16'h0);
        offer_key(8'h5A);
        @(negedge clk);
        chk("kb_int_key", 16'(kb_int), 16'h1);
        mem_read(16'hFE00, 16'hC000);
        @(negedge clk);
        chk("kb_int_held", 16'(kb_int), 16'h1);
        mem_read(16'hFE02, 16'h005A);
        @(negedge clk);
        chk("kb_int_cleared", 16'(kb_int), 16'h0);
        mem_write(16'hFE00, 16'h0000);

        // Display
        mem_write(16'hFE06, 16'h0048);
        @(negedge clk);
        chk("dsp_valid_set", 16'(dsp_valid), 16'h1);
        chk("dsp_data", 16'(dsp_data), 16'h0048);
        mem_read(16'hFE04, 16'h0000);
        mem_write(16'hFE06, 16'h0149);
        @(negedge clk);
        chk("dsp_overwrite_data", 16'(dsp_data), 16'h0049);
        chk("dsp_overwrite_valid", 16'(dsp_valid), 16'h1);
        dsp_ready = 1'b1;
        cyc();
        dsp_ready = 1'b0;
        @(negedge clk);
        chk("dsp_valid_cleared", 16'(dsp_valid), 16'h0);
        mem_read(16'hFE04, 16'h8000);
        mem_read(16'hFE06, 16'h0000);
        mem_write(16'hFE10, 16'hFFFF);
        mem_read(16'hFE10, 16'h0000);
        chk("mmio_no_sram", 16'(en_cnt - eb), 16'd0);

        // Reset in the middle of a write
        mem_write(16'hFE06, 16'h0050);
        set_mar(16'h3010);
        set_mdr(16'h7777);
        mio_en = 1'b1; rw = 1'b1;
        cyc();
        arst = 1'b1; mio_en = 1'b0; rw = 1'b0;
        wb = we_cnt;
        @(negedge clk);
        chk("abort_rdy", 16'(rdy), 16'h0);
        chk("abort_dsp_valid", 16'(dsp_valid), 16'h0);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        repeat (4) cyc();
        chk("abort_no_we", 16'(we_cnt - wb), 16'd0);
        chk("abort_rdy_idle", 16'(rdy), 16'h0);
        mem_read(16'hFE04, 16'h8000);
        mem_read(16'h3000, 16'h1234);

        // MCR
`ifdef LC3_MEM_MCR_EN
        mem_write(16'hFFFE, 16'h0000);
        @(negedge clk);
        chk("run_cleared", 16'(run), 16'h0);
        mem_read(16'hFFFE, 16'h0000);
        mem_write(16'hFFFE, 16'h8123);
        @(negedge clk);
        chk("run_set", 16'(run), 16'h1);
        mem_read(16'hFFFE, 16'h8123);
`else
        mem_read(16'hFFFE, 16'h0000);
        mem_write(16'hFFFE, 16'h8123);
        mem_read(16'hFFFE, 16'h0000);
`endif

        repeat (2) cyc();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_ctrl.md
# lc3_mem_ctrl

Memory and device controller sitting directly downstream of the LC-3 `cpu` on its shared 16-bit bus. It owns MAR/MDR and the `mem_rdy` handshake, and turns CPU memory cycles into synchronous-SRAM accesses or memory-mapped I/O register accesses. It replaces the zero-wait-state behavioural memory, adding configurable wait states, a keyboard/display device pair and a keyboard interrupt request.

## Interface
Parameters:
- `WAIT_STATES`, default 2: cycles spent in ACCESS per memory cycle. Legal range is 1..15, and values below 1 are clamped to 1.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `arst`  in  1  asynchronous reset, active-high.
- `bus`  inout  16  CPU system bus. Driven with MDR when `gate_mdr`=1; high-Z otherwise.
- `rdy`  out  1  memory-cycle complete. Connects to the CPU's `mem_rdy`.
- `ld_mar`, `ld_mdr`, `gate_mdr`, `mio_en`, `rw`  in  1 each  CPU memory control signals; `rw`=1 means write.
- `sram_en`  out  1  SRAM access strobe.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  16  SRAM address.
- `sram_wdata`  out  16  SRAM write data.
- `sram_rdata`  in  16  SRAM read data, valid 1 cycle after `sram_en`.
- `kb_valid`  in  1  keyboard character offered.
- `kb_data`  in  8  keyboard character.
- `kb_ready`  out  1  keyboard character accepted (valid/ready handshake).
- `dsp_valid`  out  1  display character pending.
- `dsp_data`  out  8  display character.
- `dsp_ready`  in  1  display accepts the pending character.
- `kb_int`  out  1  keyboard interrupt request, level.
- `run`  out  1  MCR[15]. Only present with the MCR feature.

## Operation
- MAR: loaded from `bus` on `ld_mar`.
- MDR: loaded on `ld_mdr`. The source depends on `mio_en`:
  - `mio_en`=0: MDR loads from `bus`.
  - `mio_en`=1, `rw`=0: MDR loads the read data, but only on the cycle where `rdy`=1.
- Address decode: MAR ≥ xFE00 is MMIO and never reaches SRAM. Register map:
  - KBSR xFE00: bit15 = ready, bit14 = IE. Only IE is writable.
  - KBDR xFE02: read-only. A read clears KBSR[15].
  - DSR xFE04: bit15 = ready. Read-only.
  - DDR xFE06: write-only.
  - MCR xFFFE.
  - Any other MMIO address reads x0000 and ignores writes.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE → ACCESS when `mio_en`=1. This is the issue cycle; the wait counter loads `WAIT_STATES`-1.
  - ACCESS → DONE when the counter reaches 0; otherwise the counter decrements.
  - DONE → IDLE unconditionally. If `mio_en` is still 1 in the next IDLE cycle, a new access starts (back-to-back cycles are legal).
- SRAM access, on the issue cycle only:
  - Read: `sram_en`=1, `sram_addr`=MAR.
  - Write: additionally `sram_we`=1 and `sram_wdata`=MDR.
  - Read data is captured into a hold register on the following cycle.
- MMIO access: reads sample the register on the issue cycle. Writes commit on the issue cycle.
- Keyboard:
  - `kb_ready` = !KBSR[15].
  - On a `kb_valid`&`kb_ready` transfer: KBDR ← {8'h00, `kb_data`} and KBSR[15] ← 1.
  - `kb_int` = KBSR[15] & KBSR[14].
- Display:
  - A DDR write sets `dsp_data` ← MDR[7:0], `dsp_valid` ← 1 and DSR[15] ← 0.
  - On a `dsp_valid`&`dsp_ready` transfer: `dsp_valid` ← 0 and DSR[15] ← 1.
  - A DDR write while `dsp_valid`=1 overwrites `dsp_data` and keeps `dsp_valid` high.
- Simultaneous events:
  - A KBDR read and a new key in the same cycle cannot occur, because `kb_ready`=0 while KBSR[15]=1. A new key is accepted on the cycle after the read.
  - `ld_mar` during ACCESS is ignored. The CPU must hold MAR stable until `rdy`.

## Timing
- Reset values:
  - FSM: IDLE.
  - Outputs: `rdy`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, `kb_ready`=1, `dsp_valid`=0, `dsp_data`=0, `kb_int`=0, `run`=1.
  - Registers: MAR=0, MDR=0, KBSR=0, KBDR=0, DSR=x8000, MCR=x8000.
  - `bus` follows `gate_mdr` as usual.
- Reset mid-access aborts the access: no SRAM write is issued after reset deasserts, and the FSM resumes in IDLE.
- `rdy` = (state==DONE). It is registered-state derived, with no combinational path from `mio_en`.
- Latency from the first `mio_en` cycle to the `rdy` cycle is `WAIT_STATES`+1 cycles (3 cycles at the default).

## Configuration
- `LC3_MEM_MCR_EN` defined:
  - MCR exists at xFFFE, reset x8000, fully writable.
  - `run` = MCR[15].
- `LC3_MEM_MCR_EN` undefined:
  - There is no `run` port.
  - xFFFE reads x0000 and ignores writes.

## Structure
- Package `lc3_mem_pkg` holds:
  - MMIO address constants: KBSR, KBDR, DSR, DDR, MCR, MMIO_BASE.
  - The FSM state enum.
  - The bit-position constants READY=15 and IE=14.
- One sub-module, `lc3_mmio_regs`, contains the KBSR/KBDR/DSR/DDR/MCR registers, the read mux and both device handshakes.
- The bus driver reuses `tsb_h`.

## Test plan
- SRAM write then read, `WAIT_STATES`=2:
  - Write MAR=x3000, MDR=x1234 with `rw`=1.
  - Then read MAR=x3000 with `rw`=0.
  - Required: `rdy` rises 3 cycles after `mio_en`, MDR=x1234, `sram_we` asserted for exactly one cycle.
- Keyboard:
  - Drive `kb_valid`=1 with `kb_data`=x41.
  - Required: `kb_ready` drops, and a KBSR read returns x8000.
  - Read KBDR. Required: returns x0041, and a subsequent KBSR read returns x0000.
- Interrupt:
  - Write KBSR=x4000, then offer a key.
  - Required: `kb_int`=1 until KBDR is read.
- Display:
  - Write DDR=x0048 with `dsp_ready`=0.
  - Required: `dsp_valid`=1, `dsp_data`=x48, DSR reads x0000.
  - Raise `dsp_ready`. Required: DSR reads x8000.
- Reset mid-access:
  - Assert `arst` in ACCESS during a write.
  - Required: no `sram_we` pulse, `rdy`=0, DSR=x8000. A following read completes normally.
- MCR:
  - With `LC3_MEM_MCR_EN`: write xFFFE=x0000. Required: `run`=0.
  - Without the macro: xFFFE reads x0000.
